dmem_access_ctrl: RTL

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

---
 rtl/dmem_access_ctrl_pkg.sv | 29 ++
 rtl/dmem_timeout_ctr.sv | 37 +++
 rtl/dmem_access_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: word width,
// FSM encodings, request payload and a saturating counter helper.
package dmem_access_ctrl_pkg;

    localparam int unsigned WORD_SIZE = 16;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned TMO_W     = 8;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_REQ_ENC  = 2'd1;
    localparam logic [1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_REQ  = ST_REQ_ENC,
        ST_DONE = ST_DONE_ENC
    } state_e;

    typedef struct packed {
        logic                 we;
        logic [WORD_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] wdata;
    } dmem_req_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Counts cycles spent waiting for d_ack; expired_c is high on the
// TIMEOUT-th waiting cycle.
module dmem_timeout_ctr
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired_c
);

    logic [TMO_W-1:0] count_q;
    logic [TMO_W-1:0] count_d;

    assign expired_c = en && (count_q == TMO_W'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && !expired_c) begin
            count_d = count_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: issues one request per load/store,
// stalls the pipeline until completion, handles timeout and illegal requests.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 em_valid,
    input  logic                 em_mem_read,
    input  logic                 em_mem_write,
    input  logic [WORD_SIZE-1:0] em_addr,
    input  logic [WORD_SIZE-1:0] em_wdata,
    output logic                 mem_stall,
    output logic                 d_req,
    output logic                 d_we,
    output logic [WORD_SIZE-1:0] d_addr,
    output logic [WORD_SIZE-1:0] d_wdata,
    input  logic                 d_ack,
    input  logic [WORD_SIZE-1:0] d_rdata,
    output logic [WORD_SIZE-1:0] mw_rdata,
    output logic                 mw_done,
    output logic                 mw_err,
    output logic [CNT_W-1:0]     rd_count,
    output logic [CNT_W-1:0]     wr_count
);

    state_e               state_q,    state_d;
    dmem_req_t            req_q,      req_d;
    logic                 d_req_q,    d_req_d;
    logic [WORD_SIZE-1:0] mw_rdata_q, mw_rdata_d;
    logic                 mw_done_q,  mw_done_d;
    logic                 mw_err_q,   mw_err_d;
    logic [CNT_W-1:0]     rd_count_q, rd_count_d;
    logic [CNT_W-1:0]     wr_count_q, wr_count_d;

    logic access_c;
    logic illegal_c;
    logic tmo_clear_c;
    logic tmo_expired_c;

    assign access_c  = em_valid & (em_mem_read | em_mem_write);
    assign illegal_c = em_mem_read & em_mem_write;
    assign mem_stall = ((state_q == ST_IDLE) & access_c) | (state_q == ST_REQ);

    dmem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clear     (tmo_clear_c),
        .en        (state_q == ST_REQ),
        .expired_c (tmo_expired_c)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        d_req_d     = d_req_q;
        mw_rdata_d  = mw_rdata_q;
        mw_done_d   = 1'b0;
        mw_err_d    = 1'b0;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        tmo_clear_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access_c) begin
                    if (illegal_c) begin
                        mw_err_d  = 1'b1;
                        mw_done_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        req_d.we    = em_mem_write;
                        req_d.addr  = em_addr;
                        req_d.wdata = em_wdata;
                        d_req_d     = 1'b1;
                        tmo_clear_c = 1'b1;
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // An ack arriving together with expiry wins.
                if (d_ack) begin
                    d_req_d   = 1'b0;
                    mw_done_d = 1'b1;
                    state_d   = ST_DONE;
                    if (req_q.we) begin
                        wr_count_d = sat_inc(wr_count_q);
                    end else begin
                        mw_rdata_d = d_rdata;
                        rd_count_d = sat_inc(rd_count_q);
                    end
                end else if (tmo_expired_c) begin
                    d_req_d    = 1'b0;
                    mw_rdata_d = '1;
                    mw_err_d   = 1'b1;
                    mw_done_d  = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                d_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            d_req_q    <= 1'b0;
            mw_rdata_q <= '0;
            mw_done_q  <= 1'b0;
            mw_err_q   <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            d_req_q    <= d_req_d;
            mw_rdata_q <= mw_rdata_d;
            mw_done_q  <= mw_done_d;
            mw_err_q   <= mw_err_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign d_req    = d_req_q;
    assign d_we     = req_q.we;
    assign d_addr   = req_q.addr;
    assign d_wdata  = req_q.wdata;
    assign mw_rdata = mw_rdata_q;
    assign mw_done  = mw_done_q;
    assign mw_err   = mw_err_q;
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

endmodule
